stream_insertion_sorter: RTL and testbench
==========================================

# stream_insertion_sorter

Parametrised streaming insertion sorter: accepts one keyed element per cycle over a valid/ready handshake, keeps up to DEPTH elements fully sorted in registers, and exposes the whole sorted array packed on wide outputs. It also drains the current head element (minimum, or maximum in descending mode) over a second valid/ready port. This generation adds configurable width and depth, backpressure, runtime sort direction, a drain port and a synchronous clear.

## Interface
- DEPTH, 64: number of sort slots, ≥2
- DATA_W, 8: key width, unsigned compare
- TAG_W, 8: tag width (source address carried with each key)
- CNT_W, $clog2(DEPTH+1): count width
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- clear  input  1  synchronous flush of all slots; loads mode
- desc  input  1  sort direction, sampled only when clear=1 (0 = ascending, 1 = descending)
- in_valid  input  1  element offered
- in_ready  output  1  element will be accepted
- in_data  input  DATA_W  key
- in_tag  input  TAG_W  tag
- out_valid  output  1  head element available
- out_ready  input  1  consumer takes head
- out_data  output  DATA_W  slot 0 key
- out_tag  output  TAG_W  slot 0 tag
- sorted_data  output  DEPTH*DATA_W  slot i at bits [DATA_W*i +: DATA_W]
- sorted_tag  output  DEPTH*TAG_W  slot i at bits [TAG_W*i +: TAG_W]
- count  output  CNT_W  occupied slots
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Slots 0..count-1 are occupied and ordered: ascending mode gives slot 0 = minimum; descending mode gives slot 0 = maximum. Unoccupied slots read data=0, tag=0.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Insertion position p = number of occupied slots whose key precedes-or-equals in_data under the current mode. Ties are stable: a new key goes after existing equal keys.
- Push only: slots ≥p shift up one; the new element is written at p.
- Pop only: all slots shift down one; the top slot is vacated.
- Push+pop: the array shifts down, then the element is inserted at max(p-1, 0); count unchanged.
- in_ready = !clear & (!full | out_ready). out_valid = !clear & !empty. out_data/out_tag = slot 0 directly.
- clear=1: all slots and count are zeroed, and mode ← desc. Push and pop do not occur in that cycle.
- Mode is stable between clears; desc is ignored otherwise.
- Keys are compared unsigned at full DATA_W; tags never take part in ordering.

## Timing
- Reset (rst=0, asynchronous): all slots 0, count 0, mode ascending, empty=1, full=0, out_valid=0, in_ready=1 (with clear=0). Reset takes effect without a clock edge and overrides any operation in progress.
- Latency 1: an element accepted at edge k appears in sorted_* and count after edge k. When it lands in slot 0, it is presented on out_* in the same cycle.
- The whole array updates in one cycle; no multi-cycle sort state.
- Throughput: one push and one pop per cycle. When full, a push is accepted only together with a pop.
- Combinational paths: out_ready→in_ready and clear→in_ready/out_valid. No path from in_valid to out_*.
- Boundaries:
  - Pop when count=1 with no push → empty next cycle.
  - Push at count=DEPTH-1 → full next cycle.
  - Push+pop when empty is impossible (out_valid=0).

## Configuration
- SORTER_TAG_EN defined: tag registers are instantiated; sorted_tag and out_tag carry tags.
- SORTER_TAG_EN undefined: no tag storage; in_tag is ignored; sorted_tag and out_tag are tied to 0. Ordering and timing are identical.

## Structure
- Package sorter_pkg: mode encoding constants (SORT_ASC=0, SORT_DESC=1), a `precedes(a, b, mode)` compare function, and a count-width helper.
- Sub-module sorter_cell: one slot. It holds key/tag/occupied and selects among hold, take-new, take-from-lower-neighbour and take-from-upper-neighbour from per-slot compare results. The top level generates DEPTH cells and computes shift/insert controls.

## Test plan
- Reset, then push 64 file keys with tag=index, one per cycle (DEPTH=64, DATA_W=8) → after 64 accepts full=1, in_ready=0, sorted_data matches the golden ascending list, and every tag maps back to its original key.
- Ties: push (05,0), (03,1), (05,2) → slots (03,1), (05,0), (05,2); count=3.
- Clear with desc=1, then push 10, 30, 20 → slots 30, 20, 10; out_data=30.
- Slots 03, 05, 07; out_ready=1 with push 01 in the same cycle → 03 transferred on out_*; next cycle slots 01, 05, 07, count=3.
- Full (64) with push FF and out_ready=1 in the same cycle → push accepted, old head removed, count stays 64, FF lands in slot 63.
- After 10 pushes, drive rst=0 between clock edges → count=0, empty=1, all sorted_* 0 immediately. After release, a push of 42 lands in slot 0.

Source files
------------

// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared mode encodings, cell select codes and compare helpers for the stream sorter
// Used by both the default build and the SORTER_TAG_EN build.
package sorter_pkg;

  localparam logic SORT_ASC  = 1'b0;
  localparam logic SORT_DESC = 1'b1;

  // Widest key the shared compare function accepts; callers zero-extend into it.
  localparam int KEY_MAX_W = 64;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_NEW,
    SEL_LO,
    SEL_HI,
    SEL_ZERO
  } cell_sel_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // True when key a sorts at or before key b, so equal keys keep arrival order.
  function automatic logic precedes(input logic [KEY_MAX_W-1:0] a,
                                    input logic [KEY_MAX_W-1:0] b,
                                    input logic                 mode);
    return (mode == SORT_DESC) ? (a >= b) : (a <= b);
  endfunction

endpackage

// File: rtl/sorter_cell.sv
// rtl/sorter_cell.sv - one sort slot: key, optional tag and occupied flag with a four-way source mux
// Tag storage exists only when SORTER_TAG_EN is defined; otherwise tag reads 0.
module sorter_cell
  import sorter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 8,
  parameter bit FIRST  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic              prec_lo,
  input  logic              prec_self,
  input  logic              prec_hi,
  input  logic [DATA_W-1:0] new_key,
  input  logic [TAG_W-1:0]  new_tag,
  input  logic [DATA_W-1:0] lo_key,
  input  logic [TAG_W-1:0]  lo_tag,
  input  logic              lo_occ,
  input  logic [DATA_W-1:0] hi_key,
  input  logic [TAG_W-1:0]  hi_tag,
  input  logic              hi_occ,
  output logic [DATA_W-1:0] key,
  output logic [TAG_W-1:0]  tag,
  output logic              occ
);

  cell_sel_t sel;

  // prec_* form a thermometer over the slots, so the insertion point is where it drops to 0.
  always_comb begin
    sel = SEL_HOLD;
    if (clear) begin
      sel = SEL_ZERO;
    end else if (push && !pop) begin
      if (!prec_lo)        sel = SEL_LO;
      else if (!prec_self) sel = SEL_NEW;
    end else if (pop && !push) begin
      sel = SEL_HI;
    end else if (push && pop) begin
      if (prec_hi)                sel = SEL_HI;
      else if (FIRST || prec_self) sel = SEL_NEW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key <= '0;
      occ <= 1'b0;
    end else begin
      case (sel)
        SEL_NEW:  begin key <= new_key; occ <= 1'b1;   end
        SEL_LO:   begin key <= lo_key;  occ <= lo_occ; end
        SEL_HI:   begin key <= hi_key;  occ <= hi_occ; end
        SEL_ZERO: begin key <= '0;      occ <= 1'b0;   end
        default:  begin key <= key;     occ <= occ;    end
      endcase
    end
  end

`ifdef SORTER_TAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag <= '0;
    end else begin
      case (sel)
        SEL_NEW:  tag <= new_tag;
        SEL_LO:   tag <= lo_tag;
        SEL_HI:   tag <= hi_tag;
        SEL_ZERO: tag <= '0;
        default:  tag <= tag;
      endcase
    end
  end
`else
  logic unused_tag;
  assign unused_tag = ^{new_tag, lo_tag, hi_tag};
  assign tag        = '0;
`endif

endmodule

// File: rtl/stream_insertion_sorter.sv
// rtl/stream_insertion_sorter.sv - streaming insertion sorter with head drain port and sync clear
// Define SORTER_TAG_EN to carry a tag with every key; without it tags read 0.
module stream_insertion_sorter
  import sorter_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    desc,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic [DEPTH*DATA_W-1:0] sorted_data,
  output logic [DEPTH*TAG_W-1:0]  sorted_tag,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty
);

  logic             mode;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  // Slot i lives at index i+1; the two end entries are constant padding for the neighbour muxes.
  logic [DATA_W-1:0] key_ext [0:DEPTH+1];
  logic [TAG_W-1:0]  tag_ext [0:DEPTH+1];
  logic [DEPTH+1:0]  occ_ext;
  logic [DEPTH+1:0]  prec_ext;

  assign key_ext[0]       = '0;
  assign key_ext[DEPTH+1] = '0;
  assign tag_ext[0]       = '0;
  assign tag_ext[DEPTH+1] = '0;
  assign occ_ext[0]       = 1'b0;
  assign occ_ext[DEPTH+1] = 1'b0;
  assign prec_ext[0]       = 1'b1;
  assign prec_ext[DEPTH+1] = 1'b0;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !clear && (!full || out_ready);
  assign out_valid = !clear && !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign out_data  = key_ext[1];
  assign out_tag   = tag_ext[1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign prec_ext[i+1] = occ_ext[i+1] &&
                           precedes(KEY_MAX_W'(key_ext[i+1]), KEY_MAX_W'(in_data), mode);

    sorter_cell #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .FIRST  (i == 0)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .push      (push),
      .pop       (pop),
      .prec_lo   (prec_ext[i]),
      .prec_self (prec_ext[i+1]),
      .prec_hi   (prec_ext[i+2]),
      .new_key   (in_data),
      .new_tag   (in_tag),
      .lo_key    (key_ext[i]),
      .lo_tag    (tag_ext[i]),
      .lo_occ    (occ_ext[i]),
      .hi_key    (key_ext[i+2]),
      .hi_tag    (tag_ext[i+2]),
      .hi_occ    (occ_ext[i+2]),
      .key       (key_ext[i+1]),
      .tag       (tag_ext[i+1]),
      .occ       (occ_ext[i+1])
    );

    assign sorted_data[DATA_W*i +: DATA_W] = key_ext[i+1];
    assign sorted_tag[TAG_W*i +: TAG_W]    = tag_ext[i+1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode    <= SORT_ASC;
      count_q <= '0;
    end else if (clear) begin
      mode    <= desc;
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_insertion_sorter.sv
// tb/tb_stream_insertion_sorter.sv - self-checking bench for stream_insertion_sorter with a queue model
// Tag expectations follow SORTER_TAG_EN.
module tb_stream_insertion_sorter;

  localparam int DEPTH  = 64;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 8;
  localparam int CNT_W  = 7;

  logic                    clk;
  logic                    rst;
  logic                    clear;
  logic                    desc;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [TAG_W-1:0]        out_tag;
  logic [DEPTH*DATA_W-1:0] sorted_data;
  logic [DEPTH*TAG_W-1:0]  sorted_tag;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    empty;

  stream_insertion_sorter #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .desc        (desc),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .sorted_data (sorted_data),
    .sorted_tag  (sorted_tag),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  typedef struct {
    logic [7:0] key;
    logic [7:0] tag;
  } elem_t;

  elem_t      q[$];
  logic       m_desc;
  int         checks;
  int         errors;
  logic [7:0] keys [64];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stable insert: goes before the first element that strictly sorts after the new key.
  function automatic void model_insert(input logic [7:0] k, input logic [7:0] t);
    int pos;
    pos = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (m_desc ? (q[i].key < k) : (q[i].key > k)) begin
        pos = i;
        break;
      end
    end
    q.insert(pos, '{key: k, tag: t});
  endfunction

  always @(posedge clk) begin : model_step
    bit do_pop;
    bit do_push;
    if (rst) begin
      if (clear) begin
        q.delete();
        m_desc = desc;
      end else begin
        do_pop  = out_ready && (q.size() > 0);
        do_push = in_valid && ((q.size() < DEPTH) || out_ready);
        if (do_pop) void'(q.pop_front());
        if (do_push) model_insert(in_data, in_tag);
      end
    end
  end

  always @(negedge rst) begin
    q.delete();
    m_desc = 1'b0;
  end

  always @(negedge clk) begin : compare
    logic [511:0] ed;
    logic [511:0] et;
    logic [7:0]   eh;
    logic [7:0]   eht;
    if (rst) begin
      ed  = '0;
      et  = '0;
      eh  = '0;
      eht = '0;
      for (int i = 0; i < q.size(); i++) begin
        ed[i*8 +: 8] = q[i].key;
`ifdef SORTER_TAG_EN
        et[i*8 +: 8] = q[i].tag;
`endif
      end
      if (q.size() > 0) begin
        eh = q[0].key;
`ifdef SORTER_TAG_EN
        eht = q[0].tag;
`endif
      end
      chk("sorted_data", sorted_data, ed);
      chk("sorted_tag", sorted_tag, et);
      chk("count", 512'(count), 512'(q.size()));
      chk("full", 512'(full), 512'(q.size() == DEPTH));
      chk("empty", 512'(empty), 512'(q.size() == 0));
      chk("out_valid", 512'(out_valid), 512'(!clear && (q.size() > 0)));
      chk("in_ready", 512'(in_ready), 512'(!clear && ((q.size() < DEPTH) || out_ready)));
      chk("out_data", 512'(out_data), 512'(eh));
      chk("out_tag", 512'(out_tag), 512'(eht));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input logic [7:0] t, input bit r);
    in_valid  = v;
    in_data   = d;
    in_tag    = t;
    out_ready = r;
  endtask

  task automatic idle();
    clear = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_clear(input bit d);
    idle();
    clear = 1'b1;
    desc  = d;
    tick();
    clear = 1'b0;
    desc  = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] t);
    drive(1'b1, d, t, 1'b0);
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    clk       = 1'b0;
    rst       = 1'b0;
    clear     = 1'b0;
    desc      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_count", 512'(count), 512'(0));
    chk("rst_empty", 512'(empty), 512'(1));
    chk("rst_full", 512'(full), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_sorted", sorted_data, 512'(0));
    #4;
    rst = 1'b1;
    tick();

    // 64 keys, tag = arrival index, then check order and tag-to-key mapping.
    for (int i = 0; i < 64; i++) begin
      keys[i] = 8'($urandom_range(0, 255));
      push(keys[i], 8'(i));
    end
    drive(1'b1, 8'h11, 8'h00, 1'b0);
    #1;
    chk("fill_full", 512'(full), 512'(1));
    chk("fill_in_ready", 512'(in_ready), 512'(0));
    tick();
    idle();
    chk("fill_count_hold", 512'(count), 512'(64));
    for (int i = 0; i < 63; i++)
      chk("fill_order", 512'(sorted_data[i*8 +: 8] <= sorted_data[(i+1)*8 +: 8]), 512'(1));
    for (int i = 0; i < 64; i++) begin
`ifdef SORTER_TAG_EN
      chk("fill_tagmap", 512'(sorted_data[i*8 +: 8]), 512'(keys[sorted_tag[i*8 +: 6]]));
`else
      chk("fill_tag_zero", 512'(sorted_tag[i*8 +: 8]), 512'(0));
`endif
    end

    // Stable ties.
    do_clear(1'b0);
    push(8'h05, 8'd0);
    push(8'h03, 8'd1);
    push(8'h05, 8'd2);
    idle();
    chk("tie_slots", 512'(sorted_data[23:0]), 512'(24'h050503));
    chk("tie_count", 512'(count), 512'(3));
`ifdef SORTER_TAG_EN
    chk("tie_tags", 512'(sorted_tag[23:0]), 512'(24'h020001));
`endif

    // Simultaneous pop and push.
    do_clear(1'b0);
    push(8'h03, 8'd0);
    push(8'h05, 8'd1);
    push(8'h07, 8'd2);
    drive(1'b1, 8'h01, 8'd3, 1'b1);
    #1;
    chk("pp_out_valid", 512'(out_valid), 512'(1));
    chk("pp_out_data", 512'(out_data), 512'(8'h03));
    chk("pp_in_ready", 512'(in_ready), 512'(1));
    tick();
    idle();
    chk("pp_slots", 512'(sorted_data[23:0]), 512'(24'h070501));
    chk("pp_count", 512'(count), 512'(3));

    // Descending mode.
    do_clear(1'b1);
    push(8'h10, 8'd0);
    push(8'h30, 8'd1);
    push(8'h20, 8'd2);
    idle();
    chk("desc_slots", 512'(sorted_data[23:0]), 512'(24'h102030));
    chk("desc_head", 512'(out_data), 512'(8'h30));

    // Push FF into a full array together with a pop.
    do_clear(1'b0);
    for (int i = 0; i < 64; i++) push(8'($urandom_range(0, 254)), 8'(i));
    drive(1'b1, 8'hFF, 8'hAA, 1'b1);
    #1;
    chk("fullpp_in_ready", 512'(in_ready), 512'(1));
    tick();
    idle();
    chk("fullpp_count", 512'(count), 512'(64));
    chk("fullpp_slot63", 512'(sorted_data[63*8 +: 8]), 512'(8'hFF));
    chk("fullpp_full", 512'(full), 512'(1));

    // Asynchronous reset between clock edges.
    do_clear(1'b0);
    for (int i = 0; i < 10; i++) push(8'($urandom_range(0, 255)), 8'(i));
    idle();
    #1;
    rst = 1'b0;
    #1;
    chk("arst_count", 512'(count), 512'(0));
    chk("arst_empty", 512'(empty), 512'(1));
    chk("arst_full", 512'(full), 512'(0));
    chk("arst_out_valid", 512'(out_valid), 512'(0));
    chk("arst_in_ready", 512'(in_ready), 512'(1));
    chk("arst_sorted_data", sorted_data, 512'(0));
    chk("arst_sorted_tag", sorted_tag, 512'(0));
    #2;
    rst = 1'b1;
    push(8'h42, 8'd7);
    idle();
    chk("arst_push_slot0", 512'(sorted_data[7:0]), 512'(8'h42));
    chk("arst_push_count", 512'(count), 512'(1));

    // Random traffic with occasional clears; drain bias rises in the second half.
    for (int n = 0; n < 3000; n++) begin
      clear     = ($urandom_range(0, 39) == 0);
      desc      = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < ((n < 1500) ? 3 : 6));
      in_data   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      in_tag    = 8'($urandom_range(0, 255));
      tick();
    end
    idle();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
